// File: rtl/lcd_instr_driver_pkg.sv
// lcd_instr_driver_pkg: state encodings, LCD command constants and wait-selection helper
package lcd_instr_driver_pkg;
  typedef enum logic [2:0] {
    S_POWERON, S_INIT, S_IDLE, S_SETUP, S_PULSE, S_HOLD, S_EXEC
  } state_t;
  localparam int RS_BIT = 8;
  localparam int INIT_LEN = 4;
  localparam logic [7:0] CLR = 8'h01;
  localparam logic [7:0] HOME = 8'h02;
  localparam logic [7:0] ENTRY = 8'h06;
  localparam logic [7:0] DISP_ON = 8'h0C;
  localparam logic [7:0] FUNC_8B2L = 8'h38;
  function automatic int unsigned umax(input int unsigned a, input int unsigned b);
    return a > b ? a : b;
  endfunction
  // clear (0x01) and home (0x02/0x03) need the long execution wait
  function automatic logic is_long(input logic [8:0] w);
    return !w[RS_BIT] && w[7:2] == 6'd0 && w[7:0] != 8'd0;
  endfunction
endpackage

// File: rtl/lcd_instr_driver_if.sv
// lcd_instr_driver_if: valid/ready instruction stream {RS, D[7:0]} into the LCD driver
interface lcd_instr_driver_if;
  logic [8:0] in_instr;
  logic in_valid;
  logic in_ready;
  modport master(output in_instr, output in_valid, input in_ready);
  modport slave(input in_instr, input in_valid, output in_ready);
endinterface

// File: rtl/lcd_init_rom.sv
// lcd_init_rom: 2-bit index -> 9-bit init command word (function set, display on, entry mode, clear)
module lcd_init_rom
  import lcd_instr_driver_pkg::*;
(
  input  logic [1:0] idx,
  output logic [8:0] word
);
  always_comb
    word = idx == 2'd0 ? {1'b0, FUNC_8B2L} :
           idx == 2'd1 ? {1'b0, DISP_ON} :
           idx == 2'd2 ? {1'b0, ENTRY} : {1'b0, CLR};
endmodule

// File: rtl/lcd_instr_driver.sv
// lcd_instr_driver: timed HD44780 write cycles from a {RS, D} valid/ready stream, with power-on wait and init sequence
// Ports: clk, reset_n (async active-low); in_if (slave stream); busy, init_done; lcd_rs, lcd_rw, lcd_en, lcd_data (LCD pins)
module lcd_instr_driver
  import lcd_instr_driver_pkg::*;
#(
  parameter int unsigned T_POWERON = 750000,
  parameter int unsigned T_SETUP = 4,
  parameter int unsigned T_EN = 25,
  parameter int unsigned T_HOLD = 4,
  parameter int unsigned T_EXEC = 1850,
  parameter int unsigned T_LONG = 76000,
  parameter bit INIT_EN = 1'b1
) (
  input  logic clk,
  input  logic reset_n,
  lcd_instr_driver_if.slave in_if,
  output logic busy,
  output logic init_done,
  output logic lcd_rs,
  output logic lcd_rw,
  output logic lcd_en,
  output logic [7:0] lcd_data
);
  localparam int unsigned T_MAX = umax(umax(umax(T_POWERON, T_SETUP), umax(T_EN, T_HOLD)), umax(T_EXEC, T_LONG));
  localparam int CW = $clog2(T_MAX) + 1;
  state_t state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [1:0] idx;
  logic init_active;
  logic [8:0] rom_word;
  logic done, accept, take;
  lcd_init_rom u_rom (.idx(idx), .word(rom_word));
  assign done = cnt == '0;
  assign accept = in_if.in_valid && state == S_IDLE;
  // a zero word is consumed by the handshake but never reaches the bus
  assign take = accept && in_if.in_instr != 9'h000;
  assign in_if.in_ready = state == S_IDLE;
  assign busy = state != S_IDLE;
  assign lcd_en = state == S_PULSE;
  assign lcd_rw = 1'b0;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) state <= S_POWERON;
    else state <= state_n;
  always_comb begin
    state_n = state;
    cnt_n = cnt - 1'b1;
    unique case (state)
      S_POWERON: if (done) state_n = INIT_EN ? S_INIT : S_IDLE;
      S_INIT: begin
        state_n = S_SETUP;
        cnt_n = CW'(T_SETUP - 1);
      end
      S_IDLE: if (take) begin
        state_n = S_SETUP;
        cnt_n = CW'(T_SETUP - 1);
      end
      S_SETUP: if (done) begin
        state_n = S_PULSE;
        cnt_n = CW'(T_EN - 1);
      end
      S_PULSE: if (done) begin
        state_n = S_HOLD;
        cnt_n = CW'(T_HOLD - 1);
      end
      S_HOLD: if (done) begin
        state_n = S_EXEC;
        cnt_n = is_long({lcd_rs, lcd_data}) ? CW'(T_LONG - 1) : CW'(T_EXEC - 1);
      end
      S_EXEC: if (done) state_n = init_active && idx != 2'(INIT_LEN - 1) ? S_INIT : S_IDLE;
      default: state_n = S_POWERON;
    endcase
  end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      cnt <= CW'(T_POWERON - 1);
      idx <= '0;
      init_active <= 1'b0;
      init_done <= 1'b0;
      lcd_rs <= 1'b0;
      lcd_data <= '0;
    end else begin
      cnt <= cnt_n;
      if (state == S_INIT) {lcd_rs, lcd_data} <= rom_word;
      if (take) {lcd_rs, lcd_data} <= in_if.in_instr;
      if (state == S_POWERON && done) begin
        init_active <= INIT_EN;
        init_done <= !INIT_EN;
      end
      if (state == S_EXEC && done && init_active) begin
        if (idx == 2'(INIT_LEN - 1)) begin
          init_active <= 1'b0;
          init_done <= 1'b1;
        end else idx <= idx + 1'b1;
      end
    end
endmodule

// File: tb/tb_lcd_instr_driver.sv
// tb_lcd_instr_driver: directed table-driven checks of init sequence, timing, wait selection, NOP, held valid and reset
module tb_lcd_instr_driver;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic busy, init_done, lcd_rs, lcd_rw, lcd_en;
  logic [7:0] lcd_data;
  int total = 0;
  int bad = 0;
  always #5 clk = ~clk;
  lcd_instr_driver_if bus();
  lcd_instr_driver #(
    .T_POWERON(20), .T_SETUP(2), .T_EN(4), .T_HOLD(2), .T_EXEC(10), .T_LONG(40), .INIT_EN(1'b1)
  ) dut (
    .clk(clk), .reset_n(reset_n), .in_if(bus.slave), .busy(busy), .init_done(init_done),
    .lcd_rs(lcd_rs), .lcd_rw(lcd_rw), .lcd_en(lcd_en), .lcd_data(lcd_data)
  );
  typedef struct {
    logic [8:0] w;
    logic [8:0] out;
    int start;
    int len;
    int lat;
  } vec_t;
  vec_t v[8];
  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask
  task automatic check_init();
    int pulses = 0;
    int rdy = -1;
    int rise[4] = '{-1, -1, -1, -1};
    int word[4] = '{-1, -1, -1, -1};
    int exp_w[4] = '{'h038, 'h00C, 'h006, 'h001};
    int exp_r[4] = '{23, 42, 61, 80};
    logic en_prev = 1'b0;
    for (int n = 1; n <= 300; n++) begin
      @(negedge clk);
      if (lcd_en && !en_prev) begin
        if (pulses < 4) begin
          rise[pulses] = n;
          word[pulses] = int'({lcd_rs, lcd_data});
        end
        pulses++;
      end
      en_prev = lcd_en;
      if (bus.in_ready) begin
        rdy = n;
        break;
      end
    end
    check("init_pulses", pulses, 4);
    for (int i = 0; i < 4; i++) begin
      check("init_word", word[i], exp_w[i]);
      check("init_rise", rise[i], exp_r[i]);
    end
    check("init_ready_cycle", rdy, 126);
    check("init_done", int'(init_done), 1);
  endtask
  task automatic run_instr(input logic [8:0] w, output logic [8:0] first, output int st, output int len, output int lat);
    st = -1;
    len = 0;
    lat = -1;
    bus.in_instr = w;
    bus.in_valid = 1'b1;
    @(negedge clk);
    bus.in_valid = 1'b0;
    first = {lcd_rs, lcd_data};
    for (int k = 1; k <= 200; k++) begin
      if (k > 1) @(negedge clk);
      if (lcd_en) begin
        if (st < 0) st = k;
        len++;
      end
      if (bus.in_ready) begin
        lat = k;
        break;
      end
    end
  endtask
  initial begin
    logic [8:0] first;
    int st, len, lat;
    v[0] = '{9'h141, 9'h141, 3, 4, 19};
    v[1] = '{9'h001, 9'h001, 3, 4, 49};
    v[2] = '{9'h080, 9'h080, 3, 4, 19};
    v[3] = '{9'h000, 9'h080, -1, 0, 1};
    v[4] = '{9'h002, 9'h002, 3, 4, 49};
    v[5] = '{9'h103, 9'h103, 3, 4, 19};
    v[6] = '{9'h004, 9'h004, 3, 4, 19};
    v[7] = '{9'h003, 9'h003, 3, 4, 49};
    bus.in_instr = 9'h000;
    bus.in_valid = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_busy", int'(busy), 1);
    check("rst_ready", int'(bus.in_ready), 0);
    check("rst_en", int'(lcd_en), 0);
    check("rst_rs", int'(lcd_rs), 0);
    check("rst_rw", int'(lcd_rw), 0);
    check("rst_data", int'(lcd_data), 0);
    check("rst_init_done", int'(init_done), 0);
    reset_n = 1'b1;
    check_init();
    for (int i = 0; i < 8; i++) begin
      run_instr(v[i].w, first, st, len, lat);
      check($sformatf("vec%0d_out", i), int'(first), int'(v[i].out));
      check($sformatf("vec%0d_en_start", i), st, v[i].start);
      check($sformatf("vec%0d_en_len", i), len, v[i].len);
      check($sformatf("vec%0d_ready_lat", i), lat, v[i].lat);
    end
    check("rw_const", int'(lcd_rw), 0);
    begin
      logic [8:0] seq[3] = '{9'h141, 9'h142, 9'h143};
      int sent = 0;
      int got = 0;
      logic en_prev = 1'b0;
      for (int c = 0; c < 120; c++) begin
        if (lcd_en && !en_prev) begin
          if (got < 3) check("held_word", int'({lcd_rs, lcd_data}), int'(seq[got]));
          got++;
        end
        en_prev = lcd_en;
        if (bus.in_ready) begin
          if (sent < 3) begin
            bus.in_instr = seq[sent];
            bus.in_valid = 1'b1;
            sent++;
          end else begin
            bus.in_valid = 1'b0;
            if (got >= 3) break;
          end
        end else bus.in_instr = 9'h150 + 9'(c);
        @(negedge clk);
      end
      bus.in_valid = 1'b0;
      check("held_count", got, 3);
    end
    begin
      int seen = 0;
      bus.in_instr = 9'h141;
      bus.in_valid = 1'b1;
      @(negedge clk);
      bus.in_valid = 1'b0;
      for (int k = 0; k < 20 && !lcd_en; k++) @(negedge clk);
      seen = int'(lcd_en);
      check("rst_pulse_seen", seen, 1);
      reset_n = 1'b0;
      #1;
      check("rst_async_en", int'(lcd_en), 0);
      check("rst_async_init_done", int'(init_done), 0);
      check("rst_async_busy", int'(busy), 1);
      @(negedge clk);
      reset_n = 1'b1;
      check("rel_ready", int'(bus.in_ready), 0);
      check("rel_init_done", int'(init_done), 0);
      check_init();
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
